// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer of {PC, instruction} pairs between fetch and decode.
// Accepts up to two instructions per cycle and presents the two oldest entries to decode.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        InstrValidF,
    input  logic [31:0] InstrF0,
    input  logic [31:0] InstrF1,
    input  logic [1:0]  FetchCnt,
    input  logic        FlushF,
    input  logic [1:0]  DecodeReady,
    output logic        StallF,
    output logic        ValidD0,
    output logic        ValidD1,
    output logic [31:0] InstrD0,
    output logic [31:0] InstrD1,
    output logic [31:0] PCD0,
    output logic [31:0] PCD1
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic [1:0]    fetch_cnt, decode_cnt, n_enq, n_deq;
    logic [CW-1:0] free_slots;
    logic [AW-1:0] rd_ptr_p1, wr_ptr_p1;

    always_comb begin
        free_slots = CW'(DEPTH) - count_q;
        StallF     = free_slots < CW'(2);
        fetch_cnt  = (FetchCnt == 2'd1 || FetchCnt == 2'd2) ? FetchCnt : 2'd0;
        decode_cnt = (DecodeReady == 2'd3) ? 2'd2 : DecodeReady;
        // Stall guarantees two free slots, so an accepted packet always fits whole.
        n_enq      = (InstrValidF && !StallF && !FlushF) ? fetch_cnt : 2'd0;
        if (FlushF)
            n_deq = 2'd0;
        else if (CW'(decode_cnt) > count_q)
            n_deq = count_q[1:0];
        else
            n_deq = decode_cnt;

        if (FlushF) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(n_deq);
            wr_ptr_d = wr_ptr_q + AW'(n_enq);
            count_d  = count_q + CW'(n_enq) - CW'(n_deq);
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_p1 = wr_ptr_q + AW'(1);
    assign rd_ptr_p1 = rd_ptr_q + AW'(1);

    // Storage is never reset; valid outputs hide stale contents.
    always_ff @(posedge CLK) begin
        if (n_enq != 2'd0) begin
            pc_mem_q[wr_ptr_q]    <= PCF;
            instr_mem_q[wr_ptr_q] <= InstrF0;
        end
        if (n_enq == 2'd2) begin
            pc_mem_q[wr_ptr_p1]    <= PCF + 32'd4;
            instr_mem_q[wr_ptr_p1] <= InstrF1;
        end
    end

    assign ValidD0 = (count_q != '0);
    assign ValidD1 = (count_q >= CW'(2));
    assign InstrD0 = ValidD0 ? instr_mem_q[rd_ptr_q]  : NOP;
    assign InstrD1 = ValidD1 ? instr_mem_q[rd_ptr_p1] : NOP;
    assign PCD0    = ValidD0 ? pc_mem_q[rd_ptr_q]     : 32'h0;
    assign PCD1    = ValidD1 ? pc_mem_q[rd_ptr_p1]    : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random stimulus for fetch_queue, checked against a queue-based
// reference model of the entry stream.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic        InstrValidF;
    logic [31:0] InstrF0, InstrF1;
    logic [1:0]  FetchCnt;
    logic        FlushF;
    logic [1:0]  DecodeReady;
    logic        StallF, ValidD0, ValidD1;
    logic [31:0] InstrD0, InstrD1, PCD0, PCD1;

    int errors = 0;
    int checks = 0;

    logic [31:0] mq_pc[$];
    logic [31:0] mq_ins[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .reset(reset), .PCF(PCF), .InstrValidF(InstrValidF),
        .InstrF0(InstrF0), .InstrF1(InstrF1), .FetchCnt(FetchCnt),
        .FlushF(FlushF), .DecodeReady(DecodeReady), .StallF(StallF),
        .ValidD0(ValidD0), .ValidD1(ValidD1), .InstrD0(InstrD0),
        .InstrD1(InstrD1), .PCD0(PCD0), .PCD1(PCD1)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mq_pc.size();
        chk({tag, ".ValidD0"}, 32'(ValidD0), 32'(n >= 1));
        chk({tag, ".ValidD1"}, 32'(ValidD1), 32'(n >= 2));
        chk({tag, ".StallF"},  32'(StallF),  32'((DEPTH - n) < 2));
        chk({tag, ".PCD0"},    PCD0,    (n >= 1) ? mq_pc[0]  : 32'h0);
        chk({tag, ".InstrD0"}, InstrD0, (n >= 1) ? mq_ins[0] : NOP);
        chk({tag, ".PCD1"},    PCD1,    (n >= 2) ? mq_pc[1]  : 32'h0);
        chk({tag, ".InstrD1"}, InstrD1, (n >= 2) ? mq_ins[1] : NOP);
    endtask

    // One clock cycle: the model decides what the queue does from the inputs
    // present before the edge, then outputs are compared just after the edge.
    task automatic step(input string tag);
        int  fc, dr, ne, nd, n;
        bit  full;
        n    = mq_pc.size();
        full = (DEPTH - n) < 2;
        fc   = (FetchCnt == 2'd1 || FetchCnt == 2'd2) ? int'(FetchCnt) : 0;
        dr   = (DecodeReady == 2'd3) ? 2 : int'(DecodeReady);
        ne   = (InstrValidF && !full && !FlushF) ? fc : 0;
        nd   = FlushF ? 0 : ((dr < n) ? dr : n);
        @(posedge CLK);
        if (FlushF) begin
            mq_pc.delete();
            mq_ins.delete();
        end else begin
            for (int i = 0; i < nd; i++) begin
                void'(mq_pc.pop_front());
                void'(mq_ins.pop_front());
            end
            if (ne >= 1) begin
                mq_pc.push_back(PCF);
                mq_ins.push_back(InstrF0);
            end
            if (ne == 2) begin
                mq_pc.push_back(PCF + 32'd4);
                mq_ins.push_back(InstrF1);
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] fc,
                         input logic [1:0] dr, input logic fl);
        InstrValidF = v;
        PCF         = pc;
        FetchCnt    = fc;
        DecodeReady = dr;
        FlushF      = fl;
        InstrF0     = $urandom;
        InstrF1     = $urandom;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
        #1;
        check_all("reset_async");
        @(posedge CLK);
        #1;
        check_all("reset_held");
        #2 reset = 1'b0;
        @(posedge CLK);
        #1;

        drive(1'b1, 32'h8000_0000, 2'd2, 2'd0, 1'b0);
        step("first_packet");
        chk("first_packet.PCD0_abs", PCD0, 32'h8000_0000);
        chk("first_packet.PCD1_abs", PCD1, 32'h8000_0004);

        drive(1'b1, 32'h8000_0008, 2'd2, 2'd0, 1'b0);
        step("fill");
        chk("fill.StallF_abs", 32'(StallF), 32'd1);

        drive(1'b1, 32'h8000_0010, 2'd2, 2'd0, 1'b0);
        step("full_reject");

        drive(1'b1, 32'h8000_0010, 2'd2, 2'd2, 1'b0);
        step("drain_while_stalled");
        chk("drain_while_stalled.PCD0_abs", PCD0, 32'h8000_0008);
        drive(1'b1, 32'h8000_0010, 2'd2, 2'd0, 1'b0);
        step("enqueue_after_stall");

        drive(1'b0, 32'h0, 2'd0, 2'd1, 1'b0);
        step("to_three");
        drive(1'b1, 32'h9000_0000, 2'd2, 2'd2, 1'b1);
        step("flush");
        chk("flush.InstrD0_abs", InstrD0, NOP);

        drive(1'b1, 32'hFFFF_FFFC, 2'd2, 2'd0, 1'b0);
        step("pc_wrap");
        chk("pc_wrap.PCD1_abs", PCD1, 32'h0000_0000);
        drive(1'b0, 32'h0, 2'd0, 2'd2, 1'b0);
        step("pc_wrap_drain");
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 32'h0000_1000 + 32'(i) * 4, 2'd1, 2'd1, 1'b0);
            step("ptr_wrap");
        end

        drive(1'b1, 32'h0000_2000, 2'd3, 2'd3, 1'b0);
        step("cnt3_ignored");
        drive(1'b1, 32'h0000_2000, 2'd0, 2'd0, 1'b0);
        step("cnt0_ignored");

        drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
        step("pre_reset_hold");
        drive(1'b1, 32'h0000_3000, 2'd2, 2'd0, 1'b0);
        step("pre_reset_fill");
        drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
        #3 reset = 1'b1;
        #1;
        mq_pc.delete();
        mq_ins.delete();
        check_all("mid_reset");
        #2 reset = 1'b0;
        step("after_reset");

        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
